// File: rtl/serial_subtract_controller_pkg.sv
// Shared definitions for the nibble-serial subtract sequencer.
`default_nettype none

package serial_subtract_controller_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/universal_subtractor.sv
// 4-bit combinational subtractor; op acts as borrow-in.
`default_nettype none

module universal_subtractor (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       op,
   output logic [3:0] r,
   output logic       borrow
);

   logic [4:0] d;

   // The fifth bit goes negative exactly when a < b + op.
   assign d      = {1'b0, a} - {1'b0, b} - {4'b0000, op};
   assign r      = d[3:0];
   assign borrow = d[4];

endmodule

`default_nettype wire

// File: rtl/serial_subtract_controller.sv
// Multi-precision A - B - bin, computed one nibble per cycle on a shared 4-bit subtractor.
`default_nettype none

module serial_subtract_controller
   import serial_subtract_controller_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   a_in,
   input  logic [4*NIBBLES-1:0]   b_in,
   input  logic                   bin,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   diff,
   output logic                   bout,
   output logic                   zero
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_t               state;
   state_t               state_next;
   logic [W-1:0]         a_sh;
   logic [W-1:0]         b_sh;
   logic                 borrow_r;
   logic [IDX_W-1:0]     idx;
   logic [W-1:0]         res_next;
   logic [NIBBLE_W-1:0]  sub_r;
   logic                 sub_borrow;
   logic                 last_nib;

   universal_subtractor u_sub (
      .a      (a_sh[NIBBLE_W-1:0]),
      .b      (b_sh[NIBBLE_W-1:0]),
      .op     (borrow_r),
      .r      (sub_r),
      .borrow (sub_borrow)
   );

   assign last_nib = (idx == IDX_W'(NIBBLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (last_nib) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Partial result holds only the nibbles already produced; the new one enters at the top.
   generate
      if (NIBBLES == 1) begin : g_single
         assign res_next = sub_r;
      end else begin : g_multi
         logic [W-NIBBLE_W-1:0] res_sh;

         always_ff @(posedge clk) begin
            if (rst) begin
               res_sh <= '0;
            end else if (state == S_IDLE && start) begin
               res_sh <= '0;
            end else if (state == S_RUN) begin
               res_sh <= res_next[W-1:NIBBLE_W];
            end
         end

         assign res_next = {sub_r, res_sh};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         borrow_r <= 1'b0;
         idx      <= '0;
         diff     <= '0;
         bout     <= 1'b0;
         zero     <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh     <= a_in;
                  b_sh     <= b_in;
                  borrow_r <= bin;
                  idx      <= '0;
               end
            end
            S_RUN: begin
               a_sh     <= a_sh >> NIBBLE_W;
               b_sh     <= b_sh >> NIBBLE_W;
               borrow_r <= sub_borrow;
               idx      <= idx + 1'b1;
               if (last_nib) begin
                  diff <= res_next;
                  bout <= sub_borrow;
                  zero <= (res_next == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtract_controller.sv
// Directed self-checking bench for serial_subtract_controller with NIBBLES=4.
`default_nettype none

module tb_serial_subtract_controller;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         zero;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] prev_diff;

   serial_subtract_controller #(.NIBBLES(NIBBLES)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a_in  (a_in),
      .b_in  (b_in),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts one operation, scrambles the operand inputs afterwards, and checks timing and result.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bi, input logic [W-1:0] ediff, input logic ebout,
                         input logic ezero);
      int n;
      int busy_cnt;
      a_in  = a;
      b_in  = b;
      bin   = bi;
      start = 1'b1;
      tick();
      start = 1'b0;
      a_in  = 16'hA5C3;
      b_in  = 16'h3C5A;
      bin   = ~bi;
      check({tag, "_hold_diff"}, 32'(diff), 32'(prev_diff));
      busy_cnt = busy ? 1 : 0;
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
         if (busy) busy_cnt++;
      end
      check({tag, "_latency"}, n, NIBBLES);
      check({tag, "_busy_cycles"}, busy_cnt, NIBBLES + 1);
      check({tag, "_diff"}, 32'(diff), 32'(ediff));
      check({tag, "_bout"}, 32'(bout), 32'(ebout));
      check({tag, "_zero"}, 32'(zero), 32'(ezero));
      tick();
      check({tag, "_done_low"}, 32'(done), 0);
      check({tag, "_idle"}, 32'(busy), 0);
      prev_diff = ediff;
   endtask

   initial begin
      int n;
      int pulses;
      int last;
      int extra;
      rst   = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      bin   = 1'b0;
      prev_diff = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_diff", 32'(diff), 0);
      check("rst_bout", 32'(bout), 0);
      check("rst_zero", 32'(zero), 1);
      tick();
      check("idle_no_start", 32'(busy), 0);

      run_op("t1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
      run_op("t2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      run_op("t3", 16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b1);

      // Start pulse during RUN must be ignored.
      a_in = 16'h0009; b_in = 16'h0004; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a_in = 16'hFFFF; b_in = 16'h0000; start = 1'b1;
      tick();
      start = 1'b0;
      n = 2;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      check("t4_latency", n, NIBBLES);
      check("t4_diff", 32'(diff), 32'h0005);
      check("t4_bout", 32'(bout), 0);
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done || busy) extra++;
      end
      check("t4_single_done", extra, 0);
      prev_diff = 16'h0005;

      // Reset mid-operation discards the result.
      a_in = 16'h5555; b_in = 16'h1111; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_busy", 32'(busy), 0);
      check("t5_done", 32'(done), 0);
      check("t5_diff", 32'(diff), 0);
      check("t5_zero", 32'(zero), 1);
      check("t5_bout", 32'(bout), 0);
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done || busy) extra++;
      end
      check("t5_no_done", extra, 0);
      prev_diff = '0;
      run_op("t5b", 16'h0008, 16'h0007, 1'b1, 16'h0000, 1'b0, 1'b1);

      // Back-to-back operations with start held high.
      a_in = 16'h0005; b_in = 16'h0009; bin = 1'b0; start = 1'b1;
      pulses = 0;
      last = -1;
      for (int cyc = 0; cyc < 26; cyc++) begin
         tick();
         if (done) begin
            pulses++;
            check("t6_diff", 32'(diff), 32'hFFFC);
            check("t6_bout", 32'(bout), 1);
            if (last >= 0) check("t6_period", cyc - last, NIBBLES + 2);
            last = cyc;
         end
      end
      start = 1'b0;
      check("t6_pulses", pulses, 4);
      for (int i = 0; i < 8; i++) tick();
      check("t6_drained", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
